// File: rtl/hdlc_rx_checker.sv
`default_nettype none
// ============================================================================
//  Module      : hdlc_rx_checker
//  Description : Run-time protocol checker for one or more HDLC Rx channels.
//                Observes the serial Rx stream and the Rx status strobes and
//                checks three things per channel:
//                  - every flag (01111110) on the line is followed, exactly
//                    FLAG_LATENCY cycles later, by Rx_FlagDetect;
//                  - every abort detected inside a valid frame is followed,
//                    exactly ABORT_LATENCY cycles later, by Rx_AbortSignal;
//                  - optionally, Rx_FlagDetect never fires without a flag.
//                Violations are counted in saturating per-channel counters
//                and latched into sticky per-channel error flags. The block
//                only observes; it never drives the Rx datapath.
//
//  Ports       : Clk            system clock, rising edge
//                Rst            asynchronous active-low reset
//                Enable         1 = checking active, 0 = flush checker state
//                Clr            synchronous clear of counters and ErrIrq
//                Rx             serial Rx bit, one per channel
//                Rx_FlagDetect  flag-detect strobe under check
//                Rx_ValidFrame  frame-valid under check
//                Rx_AbortDetect abort-pattern detect under check
//                Rx_AbortSignal abort output under check
//                FlagErrCnt     missed flag-detect count, ch i at [i*CNT_W +: CNT_W]
//                AbortErrCnt    missed abort-signal count, same packing
//                SpurErrCnt     spurious flag-detect count, same packing
//                ErrIrq         sticky per-channel error flag
//                ErrAny         OR of ErrIrq
//
//  Revision    : 1.0  initial release
// ============================================================================
module hdlc_rx_checker #(
    parameter int NUM_CH        = 1,
    parameter int FLAG_LATENCY  = 2,
    parameter int ABORT_LATENCY = 1,
    parameter int CNT_W         = 16,
    parameter int SPURIOUS_CHK  = 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Enable,
    input  logic                    Clr,
    input  logic [NUM_CH-1:0]       Rx,
    input  logic [NUM_CH-1:0]       Rx_FlagDetect,
    input  logic [NUM_CH-1:0]       Rx_ValidFrame,
    input  logic [NUM_CH-1:0]       Rx_AbortDetect,
    input  logic [NUM_CH-1:0]       Rx_AbortSignal,
    output logic [NUM_CH*CNT_W-1:0] FlagErrCnt,
    output logic [NUM_CH*CNT_W-1:0] AbortErrCnt,
    output logic [NUM_CH*CNT_W-1:0] SpurErrCnt,
    output logic [NUM_CH-1:0]       ErrIrq,
    output logic                    ErrAny
);

    localparam logic [7:0] c_FLAG     = 8'h7E;
    localparam logic [3:0] c_FILL_MAX = 4'd8;
    localparam logic [3:0] c_FILL_HIT = 4'd7;
    localparam bit         c_SPUR_EN  = (SPURIOUS_CHK != 0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Only the seven most recent samples are needed: together with
            // the live Rx bit they form the eight-bit flag window.
            logic [6:0]               r_sr;
            logic [3:0]               r_fill;
            logic [FLAG_LATENCY-1:0]  r_flag_pipe;
            logic [ABORT_LATENCY-1:0] r_abort_pipe;
            logic [CNT_W-1:0]         r_flag_cnt;
            logic [CNT_W-1:0]         r_abort_cnt;
            logic [CNT_W-1:0]         r_spur_cnt;
            logic                     r_irq;

            logic [FLAG_LATENCY-1:0]  w_flag_pipe_nxt;
            logic [ABORT_LATENCY-1:0] w_abort_pipe_nxt;
            logic                     w_flag_hit;
            logic                     w_abort_hit;
            logic                     w_flag_due;
            logic                     w_abort_due;
            logic                     w_flag_err;
            logic                     w_spur_err;
            logic                     w_abort_err;

            // Oldest bit sits in the MSB, so 0,1,1,1,1,1,1,0 in time order
            // reads as 8'h7E. The fill guard stops stale reset/flush zeros
            // in the window from completing a flag.
            assign w_flag_hit  = Enable && ({r_sr, Rx[gi]} == c_FLAG) &&
                                 (r_fill >= c_FILL_HIT);
            assign w_abort_hit = Enable && Rx_AbortDetect[gi] && Rx_ValidFrame[gi];

            assign w_flag_due  = r_flag_pipe[FLAG_LATENCY-1];
            assign w_abort_due = r_abort_pipe[ABORT_LATENCY-1];

            // A due flag and a spurious strobe cannot coincide: the first
            // needs the last pipe stage set, the second needs it clear.
            assign w_flag_err  = Enable && w_flag_due && !Rx_FlagDetect[gi];
            assign w_spur_err  = c_SPUR_EN && Enable && Rx_FlagDetect[gi] && !w_flag_due;
            assign w_abort_err = Enable && w_abort_due && !Rx_AbortSignal[gi];

            if (FLAG_LATENCY == 1) begin : g_fpipe_one
                assign w_flag_pipe_nxt = w_flag_hit;
            end else begin : g_fpipe_multi
                assign w_flag_pipe_nxt = {r_flag_pipe[FLAG_LATENCY-2:0], w_flag_hit};
            end

            if (ABORT_LATENCY == 1) begin : g_apipe_one
                assign w_abort_pipe_nxt = w_abort_hit;
            end else begin : g_apipe_multi
                assign w_abort_pipe_nxt = {r_abort_pipe[ABORT_LATENCY-2:0], w_abort_hit};
            end

            // Observation state: shift register, fill counter, expectation
            // pipes. Disabling flushes everything so a stale expectation can
            // never mature after re-enable.
            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) begin
                    r_sr         <= '0;
                    r_fill       <= '0;
                    r_flag_pipe  <= '0;
                    r_abort_pipe <= '0;
                end else if (!Enable) begin
                    r_sr         <= '0;
                    r_fill       <= '0;
                    r_flag_pipe  <= '0;
                    r_abort_pipe <= '0;
                end else begin
                    r_sr         <= {r_sr[5:0], Rx[gi]};
                    if (r_fill != c_FILL_MAX) begin
                        r_fill <= r_fill + 4'd1;
                    end
                    r_flag_pipe  <= w_flag_pipe_nxt;
                    r_abort_pipe <= w_abort_pipe_nxt;
                end
            end

            // Error bookkeeping. Clr takes priority over any error raised in
            // the same cycle. Counters stop at all-ones instead of wrapping.
            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) begin
                    r_flag_cnt  <= '0;
                    r_abort_cnt <= '0;
                    r_spur_cnt  <= '0;
                    r_irq       <= 1'b0;
                end else if (Clr) begin
                    r_flag_cnt  <= '0;
                    r_abort_cnt <= '0;
                    r_spur_cnt  <= '0;
                    r_irq       <= 1'b0;
                end else begin
                    if (w_flag_err && (r_flag_cnt != {CNT_W{1'b1}})) begin
                        r_flag_cnt <= r_flag_cnt + CNT_W'(1);
                    end
                    if (w_abort_err && (r_abort_cnt != {CNT_W{1'b1}})) begin
                        r_abort_cnt <= r_abort_cnt + CNT_W'(1);
                    end
                    if (w_spur_err && (r_spur_cnt != {CNT_W{1'b1}})) begin
                        r_spur_cnt <= r_spur_cnt + CNT_W'(1);
                    end
                    if (w_flag_err || w_abort_err || w_spur_err) begin
                        r_irq <= 1'b1;
                    end
                end
            end

            assign FlagErrCnt [gi*CNT_W +: CNT_W] = r_flag_cnt;
            assign AbortErrCnt[gi*CNT_W +: CNT_W] = r_abort_cnt;
            assign SpurErrCnt [gi*CNT_W +: CNT_W] = r_spur_cnt;
            assign ErrIrq[gi]                     = r_irq;
        end
    endgenerate

    assign ErrAny = |ErrIrq;

endmodule
`default_nettype wire

// File: tb/tb_hdlc_rx_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hdlc_rx_checker
//  Description : Directed self-checking bench for hdlc_rx_checker. Three
//                instances share channel-0 stimulus:
//                  dut_a : defaults (1 ch, 16-bit counters, spurious check on)
//                  dut_n : 1 ch, spurious check off
//                  dut_w : 2 ch, 2-bit counters (saturation, channel isolation)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hdlc_rx_checker;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [1:0] rx;
    logic [1:0] fd;
    logic [1:0] vf;
    logic [1:0] ad;
    logic [1:0] as_;

    logic [15:0] fa_flag, fa_abort, fa_spur;
    logic [0:0]  fa_irq;
    logic        fa_any;
    logic [15:0] fn_flag, fn_abort, fn_spur;
    logic [0:0]  fn_irq;
    logic        fn_any;
    logic [3:0]  fw_flag, fw_abort, fw_spur;
    logic [1:0]  fw_irq;
    logic        fw_any;

    int n_vec;
    int n_err;

    hdlc_rx_checker dut_a (
        .Clk(clk), .Rst(rst_n), .Enable(en), .Clr(clr),
        .Rx(rx[0:0]), .Rx_FlagDetect(fd[0:0]), .Rx_ValidFrame(vf[0:0]),
        .Rx_AbortDetect(ad[0:0]), .Rx_AbortSignal(as_[0:0]),
        .FlagErrCnt(fa_flag), .AbortErrCnt(fa_abort), .SpurErrCnt(fa_spur),
        .ErrIrq(fa_irq), .ErrAny(fa_any)
    );

    hdlc_rx_checker #(.SPURIOUS_CHK(0)) dut_n (
        .Clk(clk), .Rst(rst_n), .Enable(en), .Clr(clr),
        .Rx(rx[0:0]), .Rx_FlagDetect(fd[0:0]), .Rx_ValidFrame(vf[0:0]),
        .Rx_AbortDetect(ad[0:0]), .Rx_AbortSignal(as_[0:0]),
        .FlagErrCnt(fn_flag), .AbortErrCnt(fn_abort), .SpurErrCnt(fn_spur),
        .ErrIrq(fn_irq), .ErrAny(fn_any)
    );

    hdlc_rx_checker #(.NUM_CH(2), .CNT_W(2)) dut_w (
        .Clk(clk), .Rst(rst_n), .Enable(en), .Clr(clr),
        .Rx(rx), .Rx_FlagDetect(fd), .Rx_ValidFrame(vf),
        .Rx_AbortDetect(ad), .Rx_AbortSignal(as_),
        .FlagErrCnt(fw_flag), .AbortErrCnt(fw_abort), .SpurErrCnt(fw_spur),
        .ErrIrq(fw_irq), .ErrAny(fw_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already set take effect at the edge, outputs
    // are inspected 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Eight flag bits in time order 0,1,1,1,1,1,1,0; the last one is cycle t.
    task automatic flag_bits(input int ch);
        logic [7:0] pat;
        pat = 8'h7E;
        for (int i = 7; i >= 0; i--) begin
            rx[ch] = pat[i];
            tick();
        end
        rx[ch] = 1'b1;
    endtask

    // Full flag plus the two latency cycles; detect/clear optionally asserted
    // in cycle t+2.
    task automatic send_flag(input int ch, input bit det, input bit clr_at2);
        flag_bits(ch);
        tick();                 // t+1
        fd[ch] = det;
        clr    = clr_at2;
        tick();                 // t+2
        fd[ch] = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        logic [14:0] ovl;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        clr   = 1'b0;
        rx    = 2'b11;
        fd    = 2'b00;
        vf    = 2'b00;
        ad    = 2'b00;
        as_   = 2'b00;

        // Reset state
        repeat (3) tick();
        chk("rst_flag", 32'(fa_flag), 32'd0);
        chk("rst_irq",  32'(fa_irq),  32'd0);
        chk("rst_any",  32'(fa_any),  32'd0);
        chk("rst_wflag", 32'(fw_flag), 32'd0);
        #3 rst_n = 1'b1;
        tick();

        // Flag with detect exactly two cycles after the closing zero
        send_flag(0, 1'b1, 1'b0);
        tick();
        chk("ok_flag", 32'(fa_flag), 32'd0);
        chk("ok_spur", 32'(fa_spur), 32'd0);
        chk("ok_irq",  32'(fa_irq),  32'd0);

        // Missed flag: error visible only after cycle t+2
        flag_bits(0);
        tick();
        chk("miss_t1", 32'(fa_flag), 32'd0);
        tick();
        chk("miss_cnt", 32'(fa_flag), 32'd1);
        chk("miss_irq", 32'(fa_irq),  32'd1);
        chk("miss_any", 32'(fa_any),  32'd1);
        chk("miss_ncnt", 32'(fn_flag), 32'd1);
        chk("miss_spur", 32'(fa_spur), 32'd0);
        do_clr();
        chk("clr_cnt", 32'(fa_flag), 32'd0);
        chk("clr_irq", 32'(fa_irq),  32'd0);

        // Shared-zero flags (hits 7 cycles apart), only the first detected
        ovl = 15'b011111101111110;
        for (int i = 0; i < 18; i++) begin
            rx[0] = (i < 15) ? ovl[14-i] : 1'b1;
            fd[0] = (i == 9);
            tick();
        end
        fd[0] = 1'b0;
        chk("ovl_flag", 32'(fa_flag), 32'd1);
        chk("ovl_spur", 32'(fa_spur), 32'd0);
        do_clr();

        // Spurious detect on an all-ones line
        fd[0] = 1'b1;
        tick();
        fd[0] = 1'b0;
        chk("spur_on",   32'(fa_spur), 32'd1);
        chk("spur_off",  32'(fn_spur), 32'd0);
        chk("spur_flag", 32'(fa_flag), 32'd0);
        chk("spur_nirq", 32'(fn_irq),  32'd0);
        // Disabled: strobe ignored, counters hold
        en    = 1'b0;
        fd[0] = 1'b1;
        tick();
        fd[0] = 1'b0;
        en    = 1'b1;
        chk("dis_hold", 32'(fa_spur), 32'd1);
        chk("dis_irq",  32'(fa_irq),  32'd1);
        do_clr();

        // Abort inside a valid frame, signal missing one cycle later
        ad[0] = 1'b1; vf[0] = 1'b1;
        tick();
        ad[0] = 1'b0;
        chk("abt_t0", 32'(fa_abort), 32'd0);
        tick();
        chk("abt_miss", 32'(fa_abort), 32'd1);
        chk("abt_irq",  32'(fa_irq),   32'd1);
        do_clr();
        // Abort with signal present one cycle later
        ad[0] = 1'b1;
        tick();
        ad[0] = 1'b0; as_[0] = 1'b1;
        tick();
        as_[0] = 1'b0;
        tick();
        chk("abt_ok", 32'(fa_abort), 32'd0);
        // Abort outside a valid frame launches nothing
        vf[0] = 1'b0; ad[0] = 1'b1;
        tick();
        ad[0] = 1'b0;
        tick();
        tick();
        chk("abt_novf", 32'(fa_abort), 32'd0);
        chk("abt_virq", 32'(fa_irq),   32'd0);

        // Saturation: 5 misses on 2-bit counters stop at 3
        for (int k = 0; k < 5; k++) send_flag(0, 1'b0, 1'b0);
        chk("sat_w", 32'(fw_flag[1:0]), 32'd3);
        chk("sat_a", 32'(fa_flag),      32'd5);
        // 6th miss with Clr in the violating cycle: clear wins
        send_flag(0, 1'b0, 1'b1);
        chk("clrw_cnt", 32'(fa_flag), 32'd0);
        chk("clrw_irq", 32'(fa_irq),  32'd0);
        chk("clrw_w",   32'(fw_flag), 32'd0);

        // Reset mid-pipe
        send_flag(0, 1'b0, 1'b0);
        chk("pre_rst", 32'(fa_flag), 32'd1);
        flag_bits(0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cnt", 32'(fa_flag), 32'd0);
        chk("arst_any", 32'(fa_any),  32'd0);
        chk("arst_w",   32'(fw_flag), 32'd0);
        #2 rst_n = 1'b1;
        repeat (3) tick();
        chk("arst_pipe", 32'(fa_flag), 32'd0);

        // Errors only on channel 1
        send_flag(1, 1'b0, 1'b0);
        chk("ch1_cnt", 32'(fw_flag[3:2]), 32'd1);
        chk("ch0_cnt", 32'(fw_flag[1:0]), 32'd0);
        chk("ch_irq",  32'(fw_irq),       32'd2);
        chk("ch_any",  32'(fw_any),       32'd1);
        chk("ch_a",    32'(fa_flag),      32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
